// File: rtl/alu_exec_pkg.sv
// Shared types and encodings for the multi-cycle ALU execution controller.
package alu_exec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_EXEC,
    ST_WB
  } state_t;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_CMP = 2'b01;
  localparam logic [1:0] ALUOP_AND = 2'b10;
  localparam logic [1:0] ALUOP_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/bin_shifter.sv
// Combinational one-bit shifter applied to the Rm operand before it becomes ALU Bin.
module bin_shifter
  import alu_exec_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] din,
  input  logic [1:0]   shift,
  output logic [W-1:0] dout
);

  // Select unshifted, left-by-one, logical right-by-one or arithmetic right-by-one
  always_comb begin
    dout = din;
    case (shift)
      SH_NONE: dout = din;
      SH_LSL:  dout = {din[W-2:0], 1'b0};
      SH_LSR:  dout = {1'b0, din[W-1:1]};
      SH_ASR:  dout = {din[W-1], din[W-1:1]};
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle controller that reads operands from the register file, drives the
// combinational ALU and writes the result back (or updates status for CMP).
// Register-file reads are combinational on the registered rf_rnum, so data for the
// address presented in one state is sampled on the edge that leaves that state.
module alu_exec_ctrl
  import alu_exec_pkg::*;
#(
  parameter int W      = 16,
  parameter int RNUM_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_aluop,
  input  logic [RNUM_W-1:0] in_rn,
  input  logic [RNUM_W-1:0] in_rm,
  input  logic [RNUM_W-1:0] in_rd,
  input  logic [1:0]        in_shift,
  output logic [RNUM_W-1:0] rf_rnum,
  output logic              rf_write,
  output logic [W-1:0]      rf_wdata,
  input  logic [W-1:0]      rf_rdata,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [1:0]        alu_op,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  output logic [2:0]        status,
  output logic              done
);

  state_t state, state_next;

  logic [1:0]        op_q;
  logic [1:0]        shift_q;
  logic [RNUM_W-1:0] rm_q;
  logic [RNUM_W-1:0] rd_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_shifted;

  logic              in_ready_d;
  logic              done_d;
  logic              rf_write_d;
  logic [RNUM_W-1:0] rf_rnum_d;
  logic [W-1:0]      rf_wdata_d;
  logic [W-1:0]      alu_a_d;
  logic [W-1:0]      alu_b_d;
  logic [1:0]        alu_op_d;
  logic [2:0]        status_d;

  bin_shifter #(.W(W)) u_bin_shifter (
    .din   (rf_rdata),
    .shift (shift_q),
    .dout  (b_shifted)
  );

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Sequencing: MVN has no A operand so it skips straight to reading Rm
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid) state_next = (in_aluop == ALUOP_MVN) ? ST_RD_B : ST_RD_A;
      ST_RD_A: state_next = ST_RD_B;
      ST_RD_B: state_next = ST_EXEC;
      ST_EXEC: state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Compute the value each registered output takes on entering the next state
  always_comb begin
    in_ready_d = (state_next == ST_IDLE);
    done_d     = (state_next == ST_WB);
    rf_write_d = 1'b0;
    rf_rnum_d  = rf_rnum;
    rf_wdata_d = rf_wdata;
    alu_a_d    = alu_a;
    alu_b_d    = alu_b;
    alu_op_d   = alu_op;
    status_d   = status;
    case (state_next)
      ST_RD_A: rf_rnum_d = in_rn;
      ST_RD_B: rf_rnum_d = (state == ST_IDLE) ? in_rm : rm_q;
      ST_EXEC: begin
        alu_a_d  = (op_q == ALUOP_MVN) ? '0 : a_q;
        alu_b_d  = b_shifted;
        alu_op_d = op_q;
      end
      ST_WB: begin
        rf_wdata_d = alu_out;
        case (op_q)
          ALUOP_CMP: status_d = {alu_v, alu_n, alu_z};
          ALUOP_ADD, ALUOP_AND, ALUOP_MVN: begin
            rf_write_d = 1'b1;
            rf_rnum_d  = rd_q;
          end
        endcase
      end
      default: ;
    endcase
  end

  // Output registers plus the latched instruction fields and A operand
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready <= 1'b1;
      done     <= 1'b0;
      rf_write <= 1'b0;
      rf_rnum  <= '0;
      rf_wdata <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= ALUOP_ADD;
      status   <= 3'b000;
      op_q     <= ALUOP_ADD;
      shift_q  <= SH_NONE;
      rm_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
    end else begin
      in_ready <= in_ready_d;
      done     <= done_d;
      rf_write <= rf_write_d;
      rf_rnum  <= rf_rnum_d;
      rf_wdata <= rf_wdata_d;
      alu_a    <= alu_a_d;
      alu_b    <= alu_b_d;
      alu_op   <= alu_op_d;
      status   <= status_d;
      if (state == ST_IDLE && in_valid) begin
        op_q    <= in_aluop;
        shift_q <= in_shift;
        rm_q    <= in_rm;
        rd_q    <= in_rd;
      end
      if (state == ST_RD_A) a_q <= rf_rdata;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Testbench for alu_exec_ctrl: register file and ALU environment models, a
// directed vector table, hand-written multi-cycle sequences and random instructions.
module tb_alu_exec_ctrl;

  localparam int W      = 16;
  localparam int RNUM_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_aluop;
  logic [RNUM_W-1:0] in_rn, in_rm, in_rd;
  logic [1:0]        in_shift;
  logic [RNUM_W-1:0] rf_rnum;
  logic              rf_write;
  logic [W-1:0]      rf_wdata;
  logic [W-1:0]      rf_rdata;
  logic [W-1:0]      alu_a, alu_b;
  logic [1:0]        alu_op;
  logic [W-1:0]      alu_out;
  logic              alu_z, alu_n, alu_v;
  logic [2:0]        status;
  logic              done;

  logic [W-1:0] rf     [8];
  logic [W-1:0] ref_rf [8];
  logic [2:0]   ref_status;
  logic         pre_we;
  logic [2:0]   pre_addr;
  logic [W-1:0] pre_data;
  int           checks = 0;
  int           passes = 0;
  bit           rn_seen;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [2:0]  rd;
    logic [15:0] a_val;
    logic [15:0] b_val;
    bit          exp_write;
    logic [15:0] exp_wdata;
    logic [2:0]  exp_status;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  alu_exec_ctrl #(.W(W), .RNUM_W(RNUM_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_shift(in_shift),
    .rf_rnum(rf_rnum), .rf_write(rf_write), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .status(status), .done(done)
  );

  // Register file: combinational read, synchronous write, plus a bench preload port
  assign rf_rdata = rf[rf_rnum];
  always @(posedge clk) begin
    if (rf_write) rf[rf_rnum] <= rf_wdata;
    if (pre_we)   rf[pre_addr] <= pre_data;
  end

  // Combinational ALU: ADD, CMP (subtract), AND, MVN (~Bin)
  always_comb begin
    alu_v = 1'b0;
    case (alu_op)
      2'b00:   alu_out = alu_a + alu_b;
      2'b01:   alu_out = alu_a - alu_b;
      2'b10:   alu_out = alu_a & alu_b;
      default: alu_out = ~alu_b;
    endcase
    if (alu_op == 2'b00) alu_v = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
    if (alu_op == 2'b01) alu_v = (alu_a[15] != alu_b[15]) && (alu_out[15] != alu_a[15]);
    alu_z = (alu_out == 16'h0000);
    alu_n = alu_out[15];
  end

  function automatic vec_t mkVec(logic [1:0] op, logic [1:0] sh, logic [2:0] rn, logic [2:0] rm,
                                 logic [2:0] rd, logic [15:0] a, logic [15:0] b, bit wr,
                                 logic [15:0] wd, logic [2:0] st);
    vec_t v;
    v.op = op; v.sh = sh; v.rn = rn; v.rm = rm; v.rd = rd;
    v.a_val = a; v.b_val = b; v.exp_write = wr; v.exp_wdata = wd; v.exp_status = st;
    return v;
  endfunction

  function automatic logic [15:0] refShift(logic [15:0] v, logic [1:0] sh);
    case (sh)
      2'd0:    return v;
      2'd1:    return v << 1;
      2'd2:    return v >> 1;
      default: return $signed(v) >>> 1;
    endcase
  endfunction

  // Reference: result, write flag and resulting status from plain signed/unsigned arithmetic
  task automatic refExec(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] old_st, output logic [15:0] res, output bit wr,
                         output logic [2:0] st);
    int sa, sb, d;
    sa = $signed(a);
    sb = $signed(b);
    st = old_st;
    wr = 1'b1;
    case (op)
      2'd0: res = a + b;
      2'd1: begin
        res = a - b;
        d   = sa - sb;
        wr  = 1'b0;
        st  = {(d > 32767 || d < -32768), (d < 0 && d >= -32768) || d > 32767, res == 16'h0};
      end
      2'd2: res = a & b;
      default: res = ~b;
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic loadReg(input logic [2:0] addr, input logic [15:0] data);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_we      = 1'b0;
    ref_rf[addr] = data;
  endtask

  // Issue one instruction from a negedge; returns cycles from accept to done
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                               input logic [2:0] rd, input logic [1:0] sh, output int lat);
    int waited;
    in_valid = 1'b1;
    in_aluop = op; in_rn = rn; in_rm = rm; in_rd = rd; in_shift = sh;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 0, 1);
      in_valid = 1'b0;
      lat = -1;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    rn_seen = 1'b0;
    while (!done && lat < 10) begin
      if (rf_rnum == rn) rn_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, n;
    bit any_done, any_write, wr;
    logic [15:0] res, a, b;
    logic [2:0] st, rn, rm, rd;
    logic [1:0] op, sh;
    logic [15:0] specials[5];

    specials = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
    reset = 1'b1; in_valid = 1'b0; in_aluop = 2'b00; in_rn = '0; in_rm = '0; in_rd = '0;
    in_shift = 2'b00; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0;
    ref_status = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_rf_write", rf_write, 0);
    checkOutput("reset_rf_rnum", rf_rnum, 0);
    checkOutput("reset_rf_wdata", rf_wdata, 0);
    checkOutput("reset_alu_a", alu_a, 0);
    checkOutput("reset_alu_b", alu_b, 0);
    checkOutput("reset_alu_op", alu_op, 0);
    checkOutput("reset_status", status, 0);
    checkOutput("reset_done", done, 0);

    for (int i = 0; i < 8; i++) loadReg(3'(i), 16'h0);

    vecs[0]  = mkVec(2'd0, 2'd0, 3'd0, 3'd1, 3'd2, 16'h0005, 16'h0007, 1, 16'h000C, 3'b000);
    vecs[1]  = mkVec(2'd1, 2'd0, 3'd0, 3'd1, 3'd0, 16'h0005, 16'h0007, 0, 16'h0000, 3'b010);
    vecs[2]  = mkVec(2'd1, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0005, 16'h0005, 0, 16'h0000, 3'b001);
    vecs[3]  = mkVec(2'd1, 2'd0, 3'd3, 3'd4, 3'd0, 16'h7FFF, 16'hFFFF, 0, 16'h0000, 3'b110);
    vecs[4]  = mkVec(2'd3, 2'd3, 3'd6, 3'd1, 3'd5, 16'h1234, 16'h8001, 1, 16'h3FFF, 3'b110);
    vecs[5]  = mkVec(2'd2, 2'd1, 3'd2, 3'd3, 3'd7, 16'h0F0F, 16'h00FF, 1, 16'h010E, 3'b110);
    vecs[6]  = mkVec(2'd0, 2'd2, 3'd4, 3'd5, 3'd0, 16'h0001, 16'h8000, 1, 16'h4001, 3'b110);
    vecs[7]  = mkVec(2'd0, 2'd0, 3'd1, 3'd2, 3'd1, 16'hFFFF, 16'h0001, 1, 16'h0000, 3'b110);
    vecs[8]  = mkVec(2'd1, 2'd3, 3'd0, 3'd1, 3'd0, 16'h0000, 16'h8000, 0, 16'h0000, 3'b000);
    vecs[9]  = mkVec(2'd3, 2'd1, 3'd2, 3'd6, 3'd6, 16'h0000, 16'h7FFF, 1, 16'h0001, 3'b000);
    vecs[10] = mkVec(2'd0, 2'd1, 3'd3, 3'd4, 3'd4, 16'h8000, 16'h8000, 1, 16'h8000, 3'b000);

    for (int i = 0; i < 11; i++) begin
      loadReg(vecs[i].rm, vecs[i].b_val);
      if (vecs[i].rn != vecs[i].rm) loadReg(vecs[i].rn, vecs[i].a_val);
      applyStimulus(vecs[i].op, vecs[i].rn, vecs[i].rm, vecs[i].rd, vecs[i].sh, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, (vecs[i].op == 2'd3) ? 3 : 4);
      checkOutput($sformatf("vec%0d_rf_write", i), rf_write, vecs[i].exp_write);
      if (vecs[i].exp_write) begin
        checkOutput($sformatf("vec%0d_rf_rnum", i), rf_rnum, vecs[i].rd);
        checkOutput($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
        ref_rf[vecs[i].rd] = vecs[i].exp_wdata;
      end
      checkOutput($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
      checkOutput($sformatf("vec%0d_busy_at_done", i), in_ready, 0);
      if (vecs[i].op == 2'd3) checkOutput($sformatf("vec%0d_mvn_rn_unread", i), rn_seen, 0);
      ref_status = vecs[i].exp_status;
    end

    // Back-to-back ADDs with in_valid held high throughout
    loadReg(3'd0, 16'd5);
    loadReg(3'd1, 16'd7);
    in_valid = 1'b1; in_aluop = 2'd0; in_rn = 3'd0; in_rm = 3'd1; in_rd = 3'd2; in_shift = 2'd0;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    in_rn = 3'd2; in_rm = 3'd2; in_rd = 3'd3;
    n = 1;
    while (!done && n < 10) begin @(negedge clk); n++; end
    checkOutput("b2b_first_latency", n, 4);
    checkOutput("b2b_first_rnum", rf_rnum, 2);
    checkOutput("b2b_first_wdata", rf_wdata, 12);
    @(negedge clk);
    checkOutput("b2b_ready_after_done", in_ready, 1);
    @(negedge clk);
    checkOutput("b2b_second_accepted", in_ready, 0);
    in_valid = 1'b0;
    n = 1;
    while (!done && n < 10) begin @(negedge clk); n++; end
    checkOutput("b2b_second_latency", n, 4);
    checkOutput("b2b_second_write", rf_write, 1);
    checkOutput("b2b_second_rnum", rf_rnum, 3);
    checkOutput("b2b_second_wdata", rf_wdata, 24);
    checkOutput("b2b_status", status, 0);
    ref_rf[2] = 16'd12;
    ref_rf[3] = 16'd24;

    // Reset while an ADD is in EXEC, after a CMP left a non-zero status
    loadReg(3'd6, 16'hABCD);
    applyStimulus(2'd1, 3'd0, 3'd1, 3'd0, 2'd0, lat);
    checkOutput("pre_reset_cmp_status", status, 3'b010);
    in_valid = 1'b1; in_aluop = 2'd0; in_rn = 3'd0; in_rm = 3'd1; in_rd = 3'd6; in_shift = 2'd0;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_rf_write", rf_write, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_status", status, 0);
    any_done = 1'b0;
    any_write = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_done  |= done;
      any_write |= rf_write;
    end
    checkOutput("abort_no_late_done", any_done, 0);
    checkOutput("abort_no_late_write", any_write, 0);
    checkOutput("abort_rd_untouched", rf[6], 16'hABCD);
    ref_status = 3'b000;

    // Random instructions against the reference model
    for (int i = 0; i < 8; i++) loadReg(3'(i), 16'($urandom));
    for (int t = 0; t < 60; t++) begin
      op = 2'($urandom_range(0, 3));
      sh = 2'($urandom_range(0, 3));
      rn = 3'($urandom_range(0, 7));
      rm = 3'($urandom_range(0, 7));
      rd = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) loadReg(rm, specials[$urandom_range(0, 4)]);
      if ($urandom_range(0, 3) == 0) loadReg(rn, specials[$urandom_range(0, 4)]);
      a = (op == 2'd3) ? 16'h0 : ref_rf[rn];
      b = refShift(ref_rf[rm], sh);
      refExec(op, a, b, ref_status, res, wr, st);
      applyStimulus(op, rn, rm, rd, sh, lat);
      checkOutput($sformatf("rnd%0d_latency", t), lat, (op == 2'd3) ? 3 : 4);
      checkOutput($sformatf("rnd%0d_rf_write", t), rf_write, wr);
      if (wr) begin
        checkOutput($sformatf("rnd%0d_rf_rnum", t), rf_rnum, rd);
        checkOutput($sformatf("rnd%0d_rf_wdata", t), rf_wdata, res);
        ref_rf[rd] = res;
      end
      checkOutput($sformatf("rnd%0d_status", t), status, st);
      if (op == 2'd3 && rn != rm) checkOutput($sformatf("rnd%0d_mvn_rn_unread", t), rn_seen, 0);
      ref_status = st;
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("final_r%0d", i), rf[i], ref_rf[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
